// File: rtl/ex_mem_fwd_stage_pkg.sv
// -----------------------------------------------------------------------------
// ex_mem_fwd_stage_pkg
//   Shared definitions for the EX/MEM pipeline register and its forwarding
//   comparators: the default hold threshold, the NOP encoding inserted on
//   bubbles, and the 2-bit forward-select encoding returned to the ID stage.
// -----------------------------------------------------------------------------
package ex_mem_fwd_stage_pkg;

  // hold_flag_i at or above this level freezes the EX/MEM register
  localparam logic [2:0]  HOLD_ID      = 3'b011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST_ENC = 32'h0000_0013;

  // Forward select presented to ID for each read port
  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,  // operand comes from the register file
    FWD_STALL = 2'b01,  // load in EX feeds this operand: stall one cycle
    FWD_MEM   = 2'b10,  // take the MEM-stage result (or load data)
    FWD_EX    = 2'b11   // take the EX-stage ALU result
  } fwd_sel_e;

  // True when the hold level is high enough to freeze this stage
  function automatic logic is_hold(input logic [2:0] level,
                                   input logic [2:0] threshold);
    return (level >= threshold);
  endfunction

endpackage

// File: rtl/ex_mem_fwd_stage_fwd_cmp.sv
// -----------------------------------------------------------------------------
// ex_mem_fwd_stage_fwd_cmp
//   Single read-port hazard comparator. Compares one ID read address against
//   the instruction currently in EX and the one currently in MEM and returns
//   the forward select for that port. EX is the younger producer and wins.
//
// Ports
//   i_raddr      ID read address for this port
//   i_re         ID read enable for this port
//   i_ex_valid   EX holds a real instruction
//   i_ex_we      EX instruction writes a register
//   i_ex_waddr   EX destination register
//   i_ex_load    EX instruction is a load
//   i_mem_valid  MEM holds a real instruction
//   i_mem_we     MEM write enable (already qualified by valid)
//   i_mem_waddr  MEM destination register
//   o_flag       forward select (fwd_sel_e encoding)
// -----------------------------------------------------------------------------
module ex_mem_fwd_stage_fwd_cmp
  import ex_mem_fwd_stage_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_raddr,
  input  logic          i_re,
  input  logic          i_ex_valid,
  input  logic          i_ex_we,
  input  logic [AW-1:0] i_ex_waddr,
  input  logic          i_ex_load,
  input  logic          i_mem_valid,
  input  logic          i_mem_we,
  input  logic [AW-1:0] i_mem_waddr,
  output logic [1:0]    o_flag
);

  logic w_ex_hit;
  logic w_mem_hit;

  // x0 is hard-wired to zero, so a write to it is never a producer
  assign w_ex_hit  = i_ex_valid & i_ex_we & (i_ex_waddr != '0) &
                     i_re & (i_ex_waddr == i_raddr);

  assign w_mem_hit = i_mem_valid & i_mem_we & (i_mem_waddr != '0) &
                     i_re & (i_mem_waddr == i_raddr);

  always_comb begin
    o_flag = FWD_NONE;
    if (w_ex_hit) begin
      // a load's data is not available until MEM, so it cannot be forwarded
      // from EX; request a stall and pick it up from MEM next cycle
      o_flag = i_ex_load ? FWD_STALL : FWD_EX;
    end else if (w_mem_hit) begin
      o_flag = FWD_MEM;
    end
  end

endmodule

// File: rtl/ex_mem_fwd_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_fwd_stage
//   EX/MEM pipeline register for the 5-stage core with valid tracking, flush
//   and hold, plus the two-tier (EX / MEM) operand-forwarding selects and the
//   load-use stall request fed back to the ID stage and ctrl.
//
//   Register update priority on each rising clk: rst, flush_i, hold, load.
//   Forwarding outputs are purely combinational from the EX inputs, the ID
//   read ports and the current MEM register contents.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   hold_flag_i            hold level from ctrl (freeze when >= HOLD_LEVEL)
//   flush_i                replace the instruction entering MEM by a bubble
//   ex_valid_i             EX holds a real instruction
//   inst_i                 EX instruction word
//   op1_add_op2_res_i      EX address/sum result
//   reg1_rdata_i           rs1 operand
//   reg2_rdata_i           rs2 operand (store data)
//   reg_wdata_i            EX write-back data
//   reg_we_i               EX writes a register
//   reg_waddr_i            EX destination register
//   ex_load_i              EX instruction is a load
//   id_raddr_i             ID read addresses, port k at [k*AW +: AW]
//   id_re_i                ID read enables, one per port
//   inst_o .. reg_waddr_o  registered MEM-stage fields
//   mem_valid_o            MEM holds a real instruction
//   mem_load_o             MEM instruction is a load
//   fwd_flag_o             forward select, port k at [2k+1:2k]
//   stall_req_o            load-use stall request to ctrl
// -----------------------------------------------------------------------------
module ex_mem_fwd_stage
  import ex_mem_fwd_stage_pkg::*;
#(
  parameter int          DW         = 32,
  parameter int          AW         = 5,
  parameter int          NUM_RD     = 2,
  parameter logic [2:0]  HOLD_LEVEL = HOLD_ID,
  parameter logic [31:0] NOP_INST   = NOP_INST_ENC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           hold_flag_i,
  input  logic                 flush_i,
  input  logic                 ex_valid_i,
  input  logic [31:0]          inst_i,
  input  logic [DW-1:0]        op1_add_op2_res_i,
  input  logic [DW-1:0]        reg1_rdata_i,
  input  logic [DW-1:0]        reg2_rdata_i,
  input  logic [DW-1:0]        reg_wdata_i,
  input  logic                 reg_we_i,
  input  logic [AW-1:0]        reg_waddr_i,
  input  logic                 ex_load_i,
  input  logic [NUM_RD*AW-1:0] id_raddr_i,
  input  logic [NUM_RD-1:0]    id_re_i,
  output logic [31:0]          inst_o,
  output logic [DW-1:0]        op1_add_op2_res_o,
  output logic [DW-1:0]        reg1_rdata_o,
  output logic [DW-1:0]        reg2_rdata_o,
  output logic [DW-1:0]        reg_wdata_o,
  output logic                 reg_we_o,
  output logic [AW-1:0]        reg_waddr_o,
  output logic                 mem_valid_o,
  output logic                 mem_load_o,
  output logic [2*NUM_RD-1:0]  fwd_flag_o,
  output logic                 stall_req_o
);

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic [31:0]   r_inst;
  logic [DW-1:0] r_res;
  logic [DW-1:0] r_rs1;
  logic [DW-1:0] r_rs2;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic          r_valid;
  logic          r_load;

  logic          w_hold;

  assign w_hold = is_hold(hold_flag_i, HOLD_LEVEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst  <= NOP_INST;
      r_res   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_valid <= 1'b0;
      r_load  <= 1'b0;
    end else if (flush_i) begin
      // flush beats hold: a killed instruction must not linger in MEM
      r_inst  <= NOP_INST;
      r_res   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_valid <= 1'b0;
      r_load  <= 1'b0;
    end else if (!w_hold) begin
      r_inst  <= inst_i;
      r_res   <= op1_add_op2_res_i;
      r_rs1   <= reg1_rdata_i;
      r_rs2   <= reg2_rdata_i;
      r_wdata <= reg_wdata_i;
      // side-effect bits are qualified so an EX bubble can never write or
      // be mistaken for a load downstream
      r_we    <= reg_we_i & ex_valid_i;
      r_waddr <= reg_waddr_i;
      r_valid <= ex_valid_i;
      r_load  <= ex_load_i & ex_valid_i;
    end
  end

  assign inst_o            = r_inst;
  assign op1_add_op2_res_o = r_res;
  assign reg1_rdata_o      = r_rs1;
  assign reg2_rdata_o      = r_rs2;
  assign reg_wdata_o       = r_wdata;
  assign reg_we_o          = r_we;
  assign reg_waddr_o       = r_waddr;
  assign mem_valid_o       = r_valid;
  assign mem_load_o        = r_load;

  // ---------------------------------------------------------------------------
  // Forwarding: one comparator per ID read port
  // ---------------------------------------------------------------------------
  logic [2*NUM_RD-1:0] w_fwd_flag;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    ex_mem_fwd_stage_fwd_cmp #(
      .AW (AW)
    ) u_fwd_cmp (
      .i_raddr     (id_raddr_i[g*AW +: AW]),
      .i_re        (id_re_i[g]),
      .i_ex_valid  (ex_valid_i),
      .i_ex_we     (reg_we_i),
      .i_ex_waddr  (reg_waddr_i),
      .i_ex_load   (ex_load_i),
      .i_mem_valid (r_valid),
      .i_mem_we    (r_we),
      .i_mem_waddr (r_waddr),
      .o_flag      (w_fwd_flag[2*g +: 2])
    );
  end

  assign fwd_flag_o = w_fwd_flag;

  // Any port that needs a loaded value still sitting in EX stalls ID
  logic w_stall;

  always_comb begin
    w_stall = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (w_fwd_flag[2*k +: 2] == FWD_STALL) begin
        w_stall = 1'b1;
      end
    end
  end

  assign stall_req_o = w_stall;

endmodule

// File: tb/tb_ex_mem_fwd_stage.sv
module tb_ex_mem_fwd_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [2:0]  hold;
  logic        flush;
  logic        ex_valid;
  logic [31:0] inst;
  logic [31:0] res, rs1, rs2, wd;
  logic        we;
  logic [4:0]  waddr;
  logic        ld;
  logic [9:0]  raddr;
  logic [1:0]  re;
  logic [4:0]  ra2;
  logic        re2;
  logic [14:0] raddr3;
  logic [2:0]  re3;

  logic [31:0] inst_o, res_o, rs1_o, rs2_o, wd_o;
  logic        we_o, mv_o, ml_o, stall_o;
  logic [4:0]  waddr_o;
  logic [3:0]  fwd_o;

  logic [31:0] d3_inst_o, d3_res_o, d3_rs1_o, d3_rs2_o, d3_wd_o;
  logic        d3_we_o, d3_mv_o, d3_ml_o, d3_stall_o;
  logic [4:0]  d3_waddr_o;
  logic [5:0]  d3_fwd_o;

  assign raddr3 = {ra2, raddr};
  assign re3    = {re2, re};

  ex_mem_fwd_stage dut (
    .clk (clk), .rst (rst), .hold_flag_i (hold), .flush_i (flush),
    .ex_valid_i (ex_valid), .inst_i (inst), .op1_add_op2_res_i (res),
    .reg1_rdata_i (rs1), .reg2_rdata_i (rs2), .reg_wdata_i (wd),
    .reg_we_i (we), .reg_waddr_i (waddr), .ex_load_i (ld),
    .id_raddr_i (raddr), .id_re_i (re),
    .inst_o (inst_o), .op1_add_op2_res_o (res_o), .reg1_rdata_o (rs1_o),
    .reg2_rdata_o (rs2_o), .reg_wdata_o (wd_o), .reg_we_o (we_o),
    .reg_waddr_o (waddr_o), .mem_valid_o (mv_o), .mem_load_o (ml_o),
    .fwd_flag_o (fwd_o), .stall_req_o (stall_o)
  );

  ex_mem_fwd_stage #(.NUM_RD(3)) dut3 (
    .clk (clk), .rst (rst), .hold_flag_i (hold), .flush_i (flush),
    .ex_valid_i (ex_valid), .inst_i (inst), .op1_add_op2_res_i (res),
    .reg1_rdata_i (rs1), .reg2_rdata_i (rs2), .reg_wdata_i (wd),
    .reg_we_i (we), .reg_waddr_i (waddr), .ex_load_i (ld),
    .id_raddr_i (raddr3), .id_re_i (re3),
    .inst_o (d3_inst_o), .op1_add_op2_res_o (d3_res_o), .reg1_rdata_o (d3_rs1_o),
    .reg2_rdata_o (d3_rs2_o), .reg_wdata_o (d3_wd_o), .reg_we_o (d3_we_o),
    .reg_waddr_o (d3_waddr_o), .mem_valid_o (d3_mv_o), .mem_load_o (d3_ml_o),
    .fwd_flag_o (d3_fwd_o), .stall_req_o (d3_stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [3:0]  fwd;
    logic [1:0]  p2;
    logic        stall;
    logic        mv;
    logic        we;
    logic        ml;
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic [31:0] wd;
    logic        zero;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  event chk_ev;

  task automatic cmp(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "fwd",   {28'd0, fwd_o},    {28'd0, e.fwd});
        cmp(e.name, "fwd3",  {26'd0, d3_fwd_o}, {26'd0, e.p2, e.fwd});
        cmp(e.name, "stall", {31'd0, stall_o},  {31'd0, e.stall});
        cmp(e.name, "valid", {31'd0, mv_o},     {31'd0, e.mv});
        cmp(e.name, "we",    {31'd0, we_o},     {31'd0, e.we});
        cmp(e.name, "load",  {31'd0, ml_o},     {31'd0, e.ml});
        cmp(e.name, "inst",  inst_o,            e.inst);
        cmp(e.name, "waddr", {27'd0, waddr_o},  {27'd0, e.waddr});
        cmp(e.name, "wdata", wd_o,  e.zero ? 32'd0 : e.wd);
        cmp(e.name, "res",   res_o, e.zero ? 32'd0 : e.wd + 32'd1);
        cmp(e.name, "rs1",   rs1_o, e.zero ? 32'd0 : e.wd + 32'd2);
        cmp(e.name, "rs2",   rs2_o, e.zero ? 32'd0 : e.wd + 32'd3);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] I(input int n);
    return 32'h1000_0000 + n;
  endfunction

  task automatic ex(input logic v, input logic w, input logic [4:0] a,
                    input logic l, input logic [31:0] d, input logic [31:0] in);
    ex_valid = v; we = w; waddr = a; ld = l; inst = in;
    wd = d; res = d + 32'd1; rs1 = d + 32'd2; rs2 = d + 32'd3;
  endtask

  task automatic id(input logic [4:0] a0, input logic e0,
                    input logic [4:0] a1, input logic e1);
    raddr = {a1, a0};
    re    = {e1, e0};
  endtask

  task automatic chk(input string nm, input logic [3:0] f, input logic [1:0] p2,
                     input logic st, input logic mv, input logic w, input logic ml,
                     input logic [31:0] in, input logic [4:0] a,
                     input logic [31:0] d, input logic z);
    exp_t e;
    e.name = nm; e.fwd = f; e.p2 = p2; e.stall = st; e.mv = mv; e.we = w;
    e.ml = ml; e.inst = in; e.waddr = a; e.wd = d; e.zero = z;
    q.push_back(e);
    -> chk_ev;
  endtask

  initial begin : driver
    rst = 1'b0; hold = 3'd0; flush = 1'b0; ra2 = 5'd0; re2 = 1'b0;
    ex(0, 0, 0, 0, 0, 0);
    id(0, 0, 0, 0);
    #1 rst = 1'b1;
    #2 chk("reset", 4'b0000, 2'b00, 0, 0, 0, 0, NOP, 0, 0, 1);

    @(negedge clk); rst = 1'b0;
    ex(1, 1, 5, 0, 32'h100, I(1)); id(5, 1, 0, 0);
    #2 chk("alu_ex", 4'b0011, 2'b00, 0, 0, 0, 0, NOP, 0, 0, 1);

    @(negedge clk);
    ex(1, 1, 6, 0, 32'h200, I(2)); id(5, 1, 0, 0);
    #2 chk("alu_mem", 4'b0010, 2'b00, 0, 1, 1, 0, I(1), 5, 32'h100, 0);

    @(negedge clk);
    ex(1, 1, 7, 1, 32'h300, I(3)); id(6, 1, 7, 1);
    #2 chk("lu_stall", 4'b0110, 2'b00, 1, 1, 1, 0, I(2), 6, 32'h200, 0);

    @(negedge clk);
    ex(1, 0, 8, 0, 32'h400, I(4)); id(7, 1, 7, 1);
    #2 chk("lu_mem", 4'b1010, 2'b00, 0, 1, 1, 1, I(3), 7, 32'h300, 0);

    @(negedge clk);
    ex(1, 1, 0, 0, 32'h500, I(5)); id(0, 1, 8, 1);
    #2 chk("x0_ex", 4'b0000, 2'b00, 0, 1, 0, 0, I(4), 8, 32'h400, 0);

    @(negedge clk);
    ex(1, 1, 3, 0, 32'h600, I(6)); id(3, 0, 0, 1);
    #2 chk("re_gate", 4'b0000, 2'b00, 0, 1, 1, 0, I(5), 0, 32'h500, 0);

    @(negedge clk);
    ex(0, 1, 4, 1, 32'h700, I(7)); id(4, 1, 3, 1);
    #2 chk("ex_inval", 4'b1000, 2'b00, 0, 1, 1, 0, I(6), 3, 32'h600, 0);

    @(negedge clk);
    ex(1, 1, 9, 1, 32'h800, I(8)); id(4, 1, 9, 1);
    #2 chk("inval_mem", 4'b0100, 2'b00, 1, 0, 0, 0, I(7), 4, 32'h700, 0);

    @(negedge clk);
    hold = 3'b011;
    ex(1, 1, 10, 0, 32'h900, I(9)); id(9, 1, 10, 1);
    #2 chk("hold0", 4'b1110, 2'b00, 0, 1, 1, 1, I(8), 9, 32'h800, 0);

    @(negedge clk); hold = 3'b111;
    #2 chk("hold1", 4'b1110, 2'b00, 0, 1, 1, 1, I(8), 9, 32'h800, 0);

    @(negedge clk); hold = 3'b100;
    #2 chk("hold2", 4'b1110, 2'b00, 0, 1, 1, 1, I(8), 9, 32'h800, 0);

    @(negedge clk); hold = 3'b011; flush = 1'b1;
    #2 chk("hold3", 4'b1110, 2'b00, 0, 1, 1, 1, I(8), 9, 32'h800, 0);

    @(negedge clk); flush = 1'b0; hold = 3'b010;
    ex(1, 1, 9, 0, 32'hA00, I(10)); id(9, 1, 9, 1);
    #2 chk("flush", 4'b1111, 2'b00, 0, 0, 0, 0, NOP, 0, 0, 1);

    @(negedge clk); hold = 3'b000;
    ex(1, 1, 9, 0, 32'hB00, I(11)); id(9, 1, 9, 1); ra2 = 5'd9; re2 = 1'b1;
    #2 chk("prio", 4'b1111, 2'b11, 0, 1, 1, 0, I(10), 9, 32'hA00, 0);

    @(negedge clk);
    ex(0, 1, 9, 0, 32'hC00, I(12)); id(9, 1, 9, 1);
    #2 chk("pre_rst", 4'b1010, 2'b10, 0, 1, 1, 0, I(11), 9, 32'hB00, 0);
    #1 rst = 1'b1;
    #1 chk("mid_rst", 4'b0000, 2'b00, 0, 0, 0, 0, NOP, 0, 0, 1);

    #2 -> chk_ev;
    #1;
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ex_mem_fwd_stage.md
Name: ex_mem_fwd_stage

Overview:
Parametrised EX/MEM pipeline register for the tiny 5-stage core. It adds a valid bit, flush and a bubble-insertion rule. It generalises operand forwarding to NUM_RD read ports with two tiers, EX result and MEM-stage result. Load-use hazards produce an explicit stall request instead of a bare flag. It sits between the EX stage and the MEM stage and feeds forwarding selects back to the ID stage.

Parameters:
DW, 32, datapath / register data width
AW, 5, register address width
NUM_RD, 2, number of ID-stage read ports checked for hazards
HOLD_LEVEL, 3'b011, hold_flag_i value at or above which this stage freezes
NOP_INST, 32'h0000_0013, instruction inserted on flush/bubble

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
hold_flag_i  in  3  pipeline hold level from ctrl
flush_i  in  1  kill the instruction entering MEM (branch/trap)
ex_valid_i  in  1  EX stage holds a real instruction
inst_i  in  32  EX instruction
op1_add_op2_res_i  in  DW  address/sum result
reg1_rdata_i  in  DW  rs1 operand
reg2_rdata_i  in  DW  rs2 operand (store data)
reg_wdata_i  in  DW  EX write-back data
reg_we_i  in  1  EX instruction writes a register
reg_waddr_i  in  AW  EX destination register
ex_load_i  in  1  EX instruction is a load
id_raddr_i  in  NUM_RD*AW  ID read addresses; port k at bits [k*AW +: AW]
id_re_i  in  NUM_RD  ID read-enable per port
inst_o  out  32  MEM instruction
op1_add_op2_res_o  out  DW  registered address/sum
reg1_rdata_o  out  DW  registered rs1
reg2_rdata_o  out  DW  registered rs2
reg_wdata_o  out  DW  registered write data
reg_we_o  out  1  registered write enable, qualified by valid
reg_waddr_o  out  AW  registered destination
mem_valid_o  out  1  MEM stage holds a real instruction
mem_load_o  out  1  MEM instruction is a load
fwd_flag_o  out  2*NUM_RD  per-port forward select; port k at [2k+1:2k]
stall_req_o  out  1  load-use stall request to ctrl

Behaviour:
- Reset (async, rst=1), applied immediately and independent of clk:
  - inst_o=NOP_INST; all data outputs 0.
  - reg_we_o=0, reg_waddr_o=0, mem_valid_o=0, mem_load_o=0.
- Register update priority per clk rising edge:
  - rst, then flush_i, then hold (hold_flag_i>=HOLD_LEVEL), then load.
- flush_i=1 writes a bubble, even when hold is active:
  - valid=0, we=0, load=0, inst=NOP_INST, waddr=0; data fields 0.
- Hold: every register keeps its value.
- Load: every field captures its input.
  - mem_valid_o <= ex_valid_i.
  - reg_we_o <= reg_we_i & ex_valid_i.
  - mem_load_o <= ex_load_i & ex_valid_i.
- Latency: exactly one cycle from EX inputs to MEM outputs.
- Forwarding, combinational, evaluated per port k:
  - ex_hit = ex_valid_i & reg_we_i & (reg_waddr_i!=0) & id_re_i[k] & (reg_waddr_i==raddr_k).
  - mem_hit = mem_valid_o & reg_we_o & (reg_waddr_o!=0) & id_re_i[k] & (reg_waddr_o==raddr_k).
  - Priority (EX is younger and wins):
    - ex_hit & ex_load_i gives 2'b01 (stall, load-use).
    - ex_hit & !ex_load_i gives 2'b11 (take EX result).
    - mem_hit gives 2'b10 (take MEM result / load data).
    - Otherwise 2'b00 (register file).
- stall_req_o = OR over k of (fwd_flag==2'b01).
  - ctrl answers with a hold level below HOLD_LEVEL plus an ID bubble.
  - This stage keeps loading, so the load moves to MEM and the next cycle resolves to 2'b10.
- Register x0 never matches. A port with id_re_i[k]=0 always returns 2'b00.
- Hazard outputs are a pure function of current inputs and register state, including during hold.
- A flushed stage never produces a mem_hit.

Decomposition:
- Shared package (defines.v): HOLD_ID level; NOP encoding; FWD_NONE=2'b00, FWD_STALL=2'b01, FWD_MEM=2'b10, FWD_EX=2'b11.
- Sub-module fwd_cmp: a single-port comparator. It is instantiated NUM_RD times via generate and outputs a 2-bit flag.
- Pipeline registers: gen_pipe_dff extended with a flush input and an async-reset variant.

Test Plan:
- Reset: assert rst mid-cycle with state loaded -> all outputs clear immediately; inst_o=0x00000013; fwd_flag_o=0; stall_req_o=0.
- ALU back-to-back: EX writes x5 (we=1, valid=1, load=0); ID reads raddr0=5 -> fwd_flag_o[1:0]=11. After one clk, ID again reads raddr0=5 with EX not writing x5 -> fwd_flag_o[1:0]=10.
- Load-use: EX load to x7; ID port1 reads x7 -> fwd_flag_o[3:2]=01, stall_req_o=1. Next clk (load now in MEM) -> 10, stall_req_o=0.
- x0/re gating: EX writes x0 with raddr0=0 -> 00. EX writes x3 with id_re_i[0]=0 and raddr0=3 -> 00.
- Hold then flush: hold_flag_i=3'b011 for 3 clks -> outputs unchanged. Then flush_i=1 with hold still active -> mem_valid_o=0, reg_we_o=0, inst_o=NOP.
- Priority: EX and MEM both write x9; ID reads x9 on both ports -> fwd_flag_o=4'b1111. NUM_RD=3 build: port2 reads x9 -> bits [5:4]=11.
